// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the multi-channel clock divider.
// Consumed by clk_div_gen_if, clk_div_ch and clk_div_gen.
package clk_div_pkg;

    localparam int unsigned DEF_N_CH    = 4;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_RST_PER = 1;
    localparam int unsigned DEF_RST_HI  = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RUN_PEND
    } ch_state_e;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] per;
        logic [DEF_CNT_W-1:0] hi;
    } cfg_t;

    // Width of the channel select field: one spare bit so out-of-range selects exist.
    function automatic int unsigned ch_sel_w(input int unsigned n_ch);
        return $clog2(n_ch) + 1;
    endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Valid/ready configuration port of clk_div_gen: selects a channel and carries
// its new {PER, HI}. The master drives the request, the divider answers ready.
interface clk_div_gen_if
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned CNT_W = DEF_CNT_W
);

    localparam int unsigned CH_W = ch_sel_w(N_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_per;
    logic [CNT_W-1:0] cfg_hi;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_per,
        output cfg_hi,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_per,
        input  cfg_hi,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, IDLE/RUN/RUN_PEND FSM and a one-slot
// config shadow. Optional CLKDIV_SYNC_EN adds i_sync (phase restart of running channels).
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned RST_PER = DEF_RST_PER,
    parameter int unsigned RST_HI  = DEF_RST_HI
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
`ifdef CLKDIV_SYNC_EN
    input  logic             i_sync,
`endif
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_per,
    input  logic [CNT_W-1:0] i_hi,
    output logic             o_div,
    output logic             o_tick,
    output logic             o_pend
);

    typedef struct packed {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
    } ch_cfg_t;

    localparam ch_cfg_t RST_CFG = {CNT_W'(RST_PER), CNT_W'(RST_HI)};

    ch_state_e        r_state;
    ch_state_e        w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    ch_cfg_t          r_cfg;
    ch_cfg_t          w_cfg_d;
    ch_cfg_t          r_sh;
    ch_cfg_t          w_sh_d;
    ch_cfg_t          w_new;
    logic             r_tick;
    logic             r_div;
    logic             r_pend;
    logic             w_tick_d;
    logic             w_div_d;
    logic             w_pend_d;
    logic             w_run_d;
    logic             w_sync;
    logic             w_bound;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = i_sync;
`else
    assign w_sync = 1'b0;
`endif

    assign w_new   = {i_per, i_hi};
    // A sync pulse and a natural wrap both end the current period.
    assign w_bound = (r_cnt == r_cfg.per) || w_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cfg   <= RST_CFG;
            r_sh    <= RST_CFG;
            r_tick  <= 1'b0;
            r_div   <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_cfg   <= w_cfg_d;
            r_sh    <= w_sh_d;
            r_tick  <= w_tick_d;
            r_div   <= w_div_d;
            r_pend  <= w_pend_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_cfg_d   = r_cfg;
        w_sh_d    = i_wr ? w_new : r_sh;
        unique case (r_state)
            IDLE: begin
                w_cnt_d = '0;
                if (i_wr) w_cfg_d = w_new;
                if (i_en) w_state_d = RUN;
            end
            RUN: begin
                if (!i_en) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                    if (i_wr) w_cfg_d = w_new;
                end else begin
                    w_cnt_d = w_bound ? '0 : r_cnt + CNT_W'(1);
                    if (i_wr) w_state_d = RUN_PEND;
                end
            end
            RUN_PEND: begin
                if (!i_en) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                    w_cfg_d   = r_sh;
                end else if (w_bound) begin
                    w_state_d = RUN;
                    w_cnt_d   = '0;
                    w_cfg_d   = r_sh;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase

        // Outputs are registered views of the next-cycle counter and config.
        w_run_d  = (w_state_d != IDLE);
        w_tick_d = w_run_d && (w_cnt_d == '0);
        w_div_d  = w_run_d && (w_cnt_d < w_cfg_d.hi);
        w_pend_d = (w_state_d == RUN_PEND);
    end

    assign o_div  = r_div;
    assign o_tick = r_tick;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock-enable/divider: N_CH clk_div_ch copies behind one
// valid/ready config port. Define CLKDIV_SYNC_EN to add the i_sync phase-restart input.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH    = DEF_N_CH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned RST_PER = DEF_RST_PER,
    parameter int unsigned RST_HI  = DEF_RST_HI
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_ch_en,
`ifdef CLKDIV_SYNC_EN
    input  logic            i_sync,
`endif
    clk_div_gen_if.slave    cfg,
    output logic [N_CH-1:0] o_div_out,
    output logic [N_CH-1:0] o_tick,
    output logic [N_CH-1:0] o_pend
);

    localparam int unsigned CH_W = ch_sel_w(N_CH);

    logic [N_CH-1:0] w_hit;
    logic [N_CH-1:0] w_wr;
    logic            w_xfer;

    // Out-of-range selects hit nothing: always ready, silently dropped.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_hit[i] = (cfg.cfg_ch == CH_W'(i));
        end
    end

    assign cfg.cfg_ready = ~|(w_hit & o_pend);
    assign w_xfer        = cfg.cfg_valid && cfg.cfg_ready;
    assign w_wr          = w_hit & {N_CH{w_xfer}};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .RST_PER (RST_PER),
            .RST_HI  (RST_HI)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_en   (i_ch_en[g]),
`ifdef CLKDIV_SYNC_EN
            .i_sync (i_sync),
`endif
            .i_wr   (w_wr[g]),
            .i_per  (cfg.cfg_per),
            .i_hi   (cfg.cfg_hi),
            .o_div  (o_div_out[g]),
            .o_tick (o_tick[g]),
            .o_pend (o_pend[g])
        );
    end

endmodule
